// File: rtl/alu_if.sv
// Operand/result bundle for the 4-bit registered ALU.
interface alu_if;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] ALU_Sel;
  logic [3:0] ALU_Out;
  logic       CarryOut;

  modport master (output A, B, ALU_Sel, input ALU_Out, CarryOut);
  modport slave  (input A, B, ALU_Sel, output ALU_Out, CarryOut);
endinterface

// File: rtl/alu.sv
// 4-bit unsigned ALU, 16 opcodes, single registered stage (latency 1, no stall).
module alu (
  input  logic clk,
  input  logic rst,
  alu_if.slave bus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_MUL  = 4'h2, OP_DIV  = 4'h3,
    OP_SHL  = 4'h4, OP_SHR  = 4'h5, OP_ROL  = 4'h6, OP_ROR  = 4'h7,
    OP_AND  = 4'h8, OP_OR   = 4'h9, OP_XOR  = 4'hA, OP_NOR  = 4'hB,
    OP_NAND = 4'hC, OP_XNOR = 4'hD, OP_GT   = 4'hE, OP_EQ   = 4'hF
  } op_e;

  typedef struct packed {
    logic [3:0] out;
    logic       carry;
  } res_t;

  op_e        op;
  logic [4:0] sum;
  logic [4:0] diff;
  logic [7:0] prod;
  logic [3:0] quot;
  res_t       nxt;
  res_t       res_q;

  assign op   = op_e'(bus.ALU_Sel);
  assign sum  = {1'b0, bus.A} + {1'b0, bus.B};
  // Bit 4 of the 5-bit difference is the borrow (set iff A < B).
  assign diff = {1'b0, bus.A} - {1'b0, bus.B};
  assign prod = {4'h0, bus.A} * {4'h0, bus.B};
  assign quot = (bus.B == 4'h0) ? 4'hF : (bus.A / bus.B);

  always_comb begin
    nxt = '0;
    unique case (op)
      OP_ADD:  begin nxt.out = sum[3:0];  nxt.carry = sum[4];          end
      OP_SUB:  begin nxt.out = diff[3:0]; nxt.carry = diff[4];         end
      OP_MUL:  begin nxt.out = prod[3:0]; nxt.carry = |prod[7:4];      end
      OP_DIV:  begin nxt.out = quot;      nxt.carry = (bus.B == 4'h0); end
      OP_SHL:  begin nxt.out = {bus.A[2:0], 1'b0}; nxt.carry = bus.A[3]; end
      OP_SHR:  begin nxt.out = {1'b0, bus.A[3:1]}; nxt.carry = bus.A[0]; end
      OP_ROL:  nxt.out = {bus.A[2:0], bus.A[3]};
      OP_ROR:  nxt.out = {bus.A[0], bus.A[3:1]};
      OP_AND:  nxt.out = bus.A & bus.B;
      OP_OR:   nxt.out = bus.A | bus.B;
      OP_XOR:  nxt.out = bus.A ^ bus.B;
      OP_NOR:  nxt.out = ~(bus.A | bus.B);
      OP_NAND: nxt.out = ~(bus.A & bus.B);
      OP_XNOR: nxt.out = ~(bus.A ^ bus.B);
      OP_GT:   nxt.out = {3'b000, (bus.A > bus.B)};
      OP_EQ:   nxt.out = {3'b000, (bus.A == bus.B)};
      default: nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) res_q <= '0;
    else     res_q <= nxt;
  end

  assign bus.ALU_Out  = res_q.out;
  assign bus.CarryOut = res_q.carry;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expectations queued at drive time, popped after each edge.
module tb_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  alu_if bus();

  alu dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [4:0] sb_q[$];
  logic [4:0] last_exp;

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got out=%h c=%b, want out=%h c=%b",
                  tag, got[4:1], got[0], exp[4:1], exp[0]);
  endtask

  // Reference model written from the opcode table, result packed as {out, carry}.
  function automatic logic [4:0] ref_alu(input logic [3:0] a, b, sel);
    int ai, bi, r;
    ai = a; bi = b;
    case (sel)
      4'h0: begin r = ai + bi;  return {r[3:0], r > 15}; end
      4'h1: begin r = ai - bi;  return {r[3:0], ai < bi}; end
      4'h2: begin r = ai * bi;  return {r[3:0], r > 15}; end
      4'h3: begin
        if (bi == 0) return {4'hF, 1'b1};
        r = ai / bi; return {r[3:0], 1'b0};
      end
      4'h4: begin r = ai * 2;   return {r[3:0], a[3]}; end
      4'h5: begin r = ai / 2;   return {r[3:0], a[0]}; end
      4'h6: begin r = (ai * 2) + (ai / 8); return {r[3:0], 1'b0}; end
      4'h7: begin r = (ai / 2) + ((ai % 2) * 8); return {r[3:0], 1'b0}; end
      4'h8: return {a & b, 1'b0};
      4'h9: return {a | b, 1'b0};
      4'hA: return {a ^ b, 1'b0};
      4'hB: return {~(a | b), 1'b0};
      4'hC: return {~(a & b), 1'b0};
      4'hD: return {~(a ^ b), 1'b0};
      4'hE: return {3'b000, ai > bi, 1'b0};
      default: return {3'b000, ai == bi, 1'b0};
    endcase
  endfunction

  function automatic logic [4:0] observed();
    return {bus.ALU_Out, bus.CarryOut};
  endfunction

  // Drive between edges, queue expectation, clock once, pop and compare.
  task automatic step(input string tag, input logic [3:0] a, b, sel, input logic [4:0] exp);
    logic [4:0] e;
    @(negedge clk);
    bus.A = a; bus.B = b; bus.ALU_Sel = sel;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      n_chk++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      last_exp = e;
      chk(tag, observed(), e);
    end
  endtask

  logic [3:0] sweep_out [16] = '{4'hC,4'h8,4'h4,4'h5,4'h4,4'h5,4'h5,4'h5,
                                 4'h2,4'hA,4'h8,4'h5,4'hD,4'h7,4'h1,4'h0};
  logic [15:0] sweep_c = 16'b0000_0000_0001_0100; // bit i = carry of opcode i

  initial begin
    bus.A = 4'h0; bus.B = 4'h0; bus.ALU_Sel = 4'h0;
    #12;
    chk("reset_hold", observed(), 5'h00);
    @(negedge clk); rst = 1'b0;

    step("post_reset_add", 4'hA, 4'h2, 4'h0, {4'hC, 1'b0});

    // Async reset between edges clears outputs immediately.
    step("pre_async", 4'hF, 4'hA, 4'h0, {4'h9, 1'b1});
    #2; rst = 1'b1; #1;
    chk("async_rst", observed(), 5'h00);
    // Inputs queued during reset must never reach the outputs.
    bus.A = 4'h7; bus.B = 4'h3; bus.ALU_Sel = 4'h2;
    @(posedge clk); #1;
    chk("rst_discard", observed(), 5'h00);
    @(negedge clk); rst = 1'b0;
    step("first_after_rst", 4'h7, 4'h3, 4'h2, {4'h5, 1'b1});

    for (int i = 0; i < 16; i++)
      step($sformatf("sweep_%h", i), 4'hA, 4'h2, i[3:0], {sweep_out[i], sweep_c[i]});

    step("add_carry",  4'hF, 4'hA, 4'h0, {4'h9, 1'b1});
    step("sub_borrow", 4'h2, 4'hA, 4'h1, {4'h8, 1'b1});
    step("eq_equal",   4'h7, 4'h7, 4'hF, {4'h1, 1'b0});
    step("gt_equal",   4'h7, 4'h7, 4'hE, {4'h0, 1'b0});
    step("div_zero",   4'h5, 4'h0, 4'h3, {4'hF, 1'b1});
    step("mul_nocarry",4'h3, 4'h5, 4'h2, {4'hF, 1'b0});
    step("sub_zero",   4'h9, 4'h9, 4'h1, {4'h0, 1'b0});

    // Mid-cycle input changes must not leak to outputs before the edge.
    @(negedge clk);
    bus.A = 4'hC; bus.B = 4'h4; bus.ALU_Sel = 4'h3;
    #1;
    chk("latency_hold", observed(), last_exp);
    @(posedge clk); #1;
    chk("latency_new", observed(), {4'h3, 1'b0});

    for (int i = 0; i < 40; i++) begin
      logic [3:0] a, b, s;
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      s = 4'($urandom_range(0, 15));
      step($sformatf("rand_%0d_op%h", i, s), a, b, s, ref_alu(a, b, s));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
